// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_LOAD_WAIT = 2'd2
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Halfword accesses (H/HU) share f3[1:0]=01, words use 10.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel plus the word-memory port of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    // Environment side: core issues requests, memory answers reads.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: selects byte/half from the memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = rdata;
            F3_BU:   data = {24'h0, byte_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a single-port word memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    lsu_state_e  state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] load_data;
    logic        accept;
    logic        reject;

    function automatic logic [3:0] wmask_fmt(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B:    return 4'b0001 << a;
            F3_H:    return 4'b0011 << {a[1], 1'b0};
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_fmt(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign reject = !f3_legal(bus.req_we, bus.req_funct3) ||
                    misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign reject = !f3_legal(bus.req_we, bus.req_funct3);
`endif

    lsu_load_align u_align (
        .rdata   (bus.mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (f3_q),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        if (reject) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                // Strobe cycle: stores finish here, loads wait for registered read data.
                ST_ACCESS: begin
                    if (we_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_LOAD_WAIT;
                    end
                end
                ST_LOAD_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= load_data;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_rstrb = (state == ST_ACCESS) && !we_q;
    assign bus.mem_wmask = ((state == ST_ACCESS) && we_q) ? wmask_fmt(f3_q, addr_q[1:0]) : 4'b0000;
    assign bus.mem_wdata = wdata_fmt(f3_q, wdata_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    initial bus.mem_rdata = 32'h0;

    always @(posedge clk) begin
        if (bus.mem_rstrb)
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        for (int i = 0; i < 4; i++)
            if (bus.mem_wmask[i])
                mem[bus.mem_addr[9:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it cycle by cycle until its response cycle.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int lat,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
        check_val({tag, "/ready"}, bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            check_val({tag, "/wmask"}, bus.mem_wmask, (c == 1) ? exp_mask : 4'b0000);
            check_val({tag, "/rstrb"}, bus.mem_rstrb, 32'((c == 1) && (lat == 3)));
            check_val({tag, "/rsp_valid"}, bus.rsp_valid, 32'(c == lat));
            if (c == 1) begin
                check_val({tag, "/mem_addr"}, bus.mem_addr, addr);
                if (exp_mask != 4'b0000)
                    check_val({tag, "/mem_wdata"}, bus.mem_wdata, exp_wdata);
            end
        end
        check_val({tag, "/rsp_err"}, bus.rsp_err, exp_err);
        check_val({tag, "/rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst/rsp_valid", bus.rsp_valid, 0);
        check_val("rst/rsp_err",   bus.rsp_err,   0);
        check_val("rst/rsp_rdata", bus.rsp_rdata, 0);
        check_val("rst/rstrb",     bus.mem_rstrb, 0);
        check_val("rst/wmask",     bus.mem_wmask, 0);
        check_val("rst/mem_addr",  bus.mem_addr,  0);
        check_val("rst/ready",     bus.req_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        //       tag       we  f3     addr          wdata         lat err rdata         mask     wdata
        do_req("sw100",   1, F3_W,  32'h100, 32'hDEADBEEF, 2, 0, 32'h0,        4'b1111, 32'hDEADBEEF);
        do_req("sb103",   1, F3_B,  32'h103, 32'h000000A5, 2, 0, 32'h0,        4'b1000, 32'hA5A5A5A5);
        do_req("lb103",   0, F3_B,  32'h103, 32'h0,        3, 0, 32'hFFFFFFA5, 4'b0000, 32'h0);
        do_req("lbu103",  0, F3_BU, 32'h103, 32'h0,        3, 0, 32'h000000A5, 4'b0000, 32'h0);
        do_req("lw_sb",   0, F3_W,  32'h100, 32'h0,        3, 0, 32'hA5ADBEEF, 4'b0000, 32'h0);
        do_req("sw_fill", 1, F3_W,  32'h100, 32'h80011234, 2, 0, 32'h0,        4'b1111, 32'h80011234);
        do_req("lh102",   0, F3_H,  32'h102, 32'h0,        3, 0, 32'hFFFF8001, 4'b0000, 32'h0);
        do_req("lhu102",  0, F3_HU, 32'h102, 32'h0,        3, 0, 32'h00008001, 4'b0000, 32'h0);
        do_req("lw100",   0, F3_W,  32'h100, 32'h0,        3, 0, 32'h80011234, 4'b0000, 32'h0);
        do_req("sh102",   1, F3_H,  32'h102, 32'h0000BEEF, 2, 0, 32'h0,        4'b1100, 32'hBEEFBEEF);
        do_req("lw_sh",   0, F3_W,  32'h100, 32'h0,        3, 0, 32'hBEEF1234, 4'b0000, 32'h0);
        do_req("lb100",   0, F3_B,  32'h100, 32'h0,        3, 0, 32'h00000034, 4'b0000, 32'h0);
        do_req("lb101",   0, F3_B,  32'h101, 32'h0,        3, 0, 32'h00000012, 4'b0000, 32'h0);
        do_req("lhu100",  0, F3_HU, 32'h100, 32'h0,        3, 0, 32'h00001234, 4'b0000, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw102_mis", 0, F3_W, 32'h102, 32'h0,       1, 1, 32'h0,        4'b0000, 32'h0);
        do_req("sh101_mis", 1, F3_H, 32'h101, 32'h0000AAAA, 1, 1, 32'h0,       4'b0000, 32'h0);
        do_req("lh103_mis", 0, F3_H, 32'h103, 32'h0,       1, 1, 32'h0,        4'b0000, 32'h0);
        do_req("lw_after",  0, F3_W, 32'h100, 32'h0,       3, 0, 32'hBEEF1234, 4'b0000, 32'h0);
`else
        do_req("lw102_mis", 0, F3_W, 32'h102, 32'h0,       3, 0, 32'hBEEF1234, 4'b0000, 32'h0);
        do_req("lh103_mis", 0, F3_H, 32'h103, 32'h0,       3, 0, 32'hFFFFBEEF, 4'b0000, 32'h0);
        do_req("sh101_mis", 1, F3_H, 32'h101, 32'h0000AAAA, 2, 0, 32'h0,       4'b0011, 32'hAAAAAAAA);
        do_req("lw_after",  0, F3_W, 32'h100, 32'h0,       3, 0, 32'hBEEFAAAA, 4'b0000, 32'h0);
`endif

        do_req("ld_f3_011", 0, 3'b011, 32'h100, 32'h0,       1, 1, 32'h0,     4'b0000, 32'h0);
        do_req("ld_f3_111", 0, 3'b111, 32'h100, 32'h0,       1, 1, 32'h0,     4'b0000, 32'h0);
        do_req("st_f3_100", 1, 3'b100, 32'h100, 32'h55555555, 1, 1, 32'h0,   4'b0000, 32'h0);
        do_req("st_f3_011", 1, 3'b011, 32'h100, 32'h66666666, 1, 1, 32'h0,   4'b0000, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw_nowr",   0, F3_W,   32'h100, 32'h0,       3, 0, 32'hBEEF1234, 4'b0000, 32'h0);
`else
        do_req("lw_nowr",   0, F3_W,   32'h100, 32'h0,       3, 0, 32'hBEEFAAAA, 4'b0000, 32'h0);
`endif

        // Reset while a load sits in LOAD_WAIT: the response must be dropped.
        do_req("sw104", 1, F3_W, 32'h104, 32'h11223344, 2, 0, 32'h0, 4'b1111, 32'h11223344);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h104;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check_val("rstmid/rstrb", bus.mem_rstrb, 1);
        @(posedge clk); #1;
        check_val("rstmid/lw_ready", bus.req_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("rstmid/rsp_valid0", bus.rsp_valid, 0);
        check_val("rstmid/ready",      bus.req_ready, 1);
        check_val("rstmid/mem_addr",   bus.mem_addr,  0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("rstmid/rsp_valid_n", bus.rsp_valid, 0);
        end
        do_req("sw108",  1, F3_W, 32'h108, 32'hCAFEF00D, 2, 0, 32'h0,        4'b1111, 32'hCAFEF00D);
        do_req("lw108",  0, F3_W, 32'h108, 32'h0,        3, 0, 32'hCAFEF00D, 4'b0000, 32'h0);
        do_req("lw104",  0, F3_W, 32'h104, 32'h0,        3, 0, 32'h11223344, 4'b0000, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
